// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the GMII receive path.
package eth_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // Longest run of preamble bytes accepted before the SFD.
    localparam int          MAX_PREAMBLE  = 7;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state; shared with the transmit framer.
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    // Eight LSB-first bit steps folded into one combinational update.
    always_comb begin
        crc_out = crc_in;
        // NOTE: blocking assignments here on purpose -- each loop step must see
        // the value produced by the previous step within the same evaluation.
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks FCS and length,
// forwards frame bytes through a short delay line so the FCS can be dropped.
module gmii_rx_deframer
    import eth_rx_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int STRIP_FCS = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad
);

    // Holding back four extra bytes lets the FCS fall off the end unseen.
    localparam int D = (STRIP_FCS != 0) ? 5 : 1;

    rx_state_e   state_q, state_d;
    logic [7:0]  line_q [D];
    logic [7:0]  line_d [D];
    logic [2:0]  fill_q, fill_d;
    logic [10:0] len_q, len_d;
    logic [2:0]  pre_q, pre_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic        err_seen_q, err_seen_d;
    logic        busy_q, busy_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;
    logic        frame_bad;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (gmii_rxd),
        .crc_out (crc_next)
    );

    // Next-state, frame bookkeeping and output beat selection.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        line_d     = line_q;
        fill_d     = fill_q;
        len_d      = len_q;
        pre_d      = pre_q;
        crc_d      = crc_q;
        err_seen_d = err_seen_q;
        busy_d     = gmii_rx_dv;
        tdata_d    = 8'h00;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        good_d     = good_q;
        bad_d      = bad_q;
        frame_bad  = 1'b0;

        // Outside DATA the per-frame context sits ready for the next frame.
        if (state_q != DATA) begin
            fill_d     = 3'd0;
            len_d      = 11'd0;
            crc_d      = CRC_INIT;
            err_seen_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                pre_d = 3'd0;
                if (gmii_rx_dv) begin
                    // dv already high last cycle means we joined mid-frame.
                    if (busy_q) begin
                        state_d = DROP;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                        pre_d   = 3'd1;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_d = DATA;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rx_er) begin
                    state_d = DROP;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    if (pre_q == 3'(MAX_PREAMBLE)) state_d = DROP;
                    else                            pre_d   = pre_q + 3'd1;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d = DATA;
                end else begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (len_q == 11'(MAX_FRAME + 1)) begin
                    // Oversize: close the frame on the held byte and abandon the rest.
                    tdata_d  = line_q[D-1];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    tuser_d  = 1'b1;
                    bad_d    = bad_q + 32'd1;
                    state_d  = gmii_rx_dv ? DROP : IDLE;
                end else if (gmii_rx_dv) begin
                    crc_d      = crc_next;
                    len_d      = (len_q == '1) ? len_q : len_q + 11'd1;
                    err_seen_d = err_seen_q | gmii_rx_er;
                    line_d[0]  = gmii_rxd;
                    for (int i = 1; i < D; i++) begin
                        line_d[i] = line_q[i-1];
                    end
                    if (fill_q == 3'(D)) begin
                        tdata_d  = line_q[D-1];
                        tvalid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end else begin
                    // End of frame: the oldest held byte is the final beat.
                    frame_bad = (crc_q != CRC_RESIDUE) || err_seen_q ||
                                (len_q < 11'(MIN_FRAME)) || (fill_q != 3'(D));
                    if (fill_q == 3'(D)) begin
                        tdata_d  = line_q[D-1];
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = frame_bad;
                    end
                    if (frame_bad) bad_d  = bad_q + 32'd1;
                    else           good_d = good_q + 32'd1;
                    state_d = IDLE;
                end
            end

            DROP: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state, output beat and statistics registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            fill_q     <= 3'd0;
            len_q      <= 11'd0;
            pre_q      <= 3'd0;
            crc_q      <= CRC_INIT;
            err_seen_q <= 1'b0;
            busy_q     <= 1'b1;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            good_q     <= 32'd0;
            bad_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            len_q      <= len_d;
            pre_q      <= pre_d;
            crc_q      <= crc_d;
            err_seen_q <= err_seen_d;
            busy_q     <= busy_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    // Delay line byte storage.
    // NOTE: data storage is not reset; fill_q alone says which entries are
    // meaningful, so clearing the bytes would only cost reset routing.
    always_ff @(posedge CLK) begin
        line_q <= line_d;
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign m_tuser   = tuser_q;
    assign stat_good = good_q;
    assign stat_bad  = bad_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed self-checking bench for gmii_rx_deframer (default parameters).
module tb_gmii_rx_deframer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] stat_good;
    logic [31:0] stat_bad;

    gmii_rx_deframer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .stat_good  (stat_good),
        .stat_bad   (stat_bad)
    );

    always #4 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [7:0] rx_q[$];
    int         n_tlast      = 0;
    logic       last_user    = 1'b0;
    logic [7:0] last_data    = 8'h00;
    int         tlast_cyc    = -1;
    int         sum_at_tlast = 0;
    int         idle_junk    = 0;

    always @(negedge CLK) begin
        if (m_tvalid) begin
            rx_q.push_back(m_tdata);
            if (m_tlast) begin
                n_tlast++;
                last_user    = m_tuser;
                last_data    = m_tdata;
                tlast_cyc    = cyc;
                sum_at_tlast = int'(stat_good + stat_bad);
            end
        end else if (m_tdata != 8'h00 || m_tlast || m_tuser) begin
            idle_junk++;
        end
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] frm[$];
    logic [7:0] exp_q[$];
    int exp_good = 0;
    int exp_bad  = 0;
    int mark_idx = -1;
    int mark_cyc = -1;
    int dv0_cyc  = -1;
    int post_rst_beats = 0;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Payload of npay incrementing bytes from start, followed by its FCS.
    task automatic build(input int npay, input logic [7:0] start);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            b = start + 8'(i);
            frm.push_back(b);
            exp_q.push_back(b);
            c = crc_byte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rst);
        @(negedge CLK);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
        RESET      = rst;
    endtask

    task automatic send_frame(input int npre, input int er_idx, input int rst_idx, input int ifg);
        for (int p = 0; p < npre; p++) drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, frm[i], i == er_idx, i == rst_idx);
            if (i == mark_idx) mark_cyc = cyc + 1;
            if (i == rst_idx + 1) post_rst_beats = rx_q.size();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        dv0_cyc = cyc + 1;
        for (int j = 1; j < ifg; j++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_step(input string tag, input int b0, input int t0,
                              input int beats, input int tl, input logic user);
        check({tag, ".beats"}, rx_q.size() - b0, beats);
        check({tag, ".tlast"}, n_tlast - t0, tl);
        if (tl > 0) check({tag, ".tuser"}, last_user, user);
        check({tag, ".good"}, stat_good, exp_good);
        check({tag, ".bad"}, stat_bad, exp_bad);
    endtask

    task automatic check_data(input string tag, input int b0);
        int errs = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b0 + i >= rx_q.size()) errs++;
            else if (rx_q[b0 + i] !== exp_q[i]) errs++;
        end
        check({tag, ".data_errs"}, errs, 0);
    endtask

    initial begin
        int b0;
        int t0;

        RESET = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst.tvalid", m_tvalid, 0);
        check("rst.tlast", m_tlast, 0);
        check("rst.tdata", m_tdata, 0);
        check("rst.good", stat_good, 0);
        check("rst.bad", stat_bad, 0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Basic good 64-byte frame.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h00);
        send_frame(7, -1, -1, 4);
        exp_good = 1;
        check_step("basic", b0, t0, 60, 1, 1'b0);
        check_data("basic", b0);
        check("basic.last_data", last_data, 8'h3B);
        check("basic.latency", tlast_cyc, dv0_cyc);
        check("basic.cnt_at_tlast", sum_at_tlast, 1);

        // Corrupted FCS.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h00);
        frm[63] = frm[63] ^ 8'h01;
        send_frame(7, -1, -1, 4);
        exp_bad = 1;
        check_step("badfcs", b0, t0, 60, 1, 1'b1);
        check_data("badfcs", b0);

        // rx_er on payload byte 10.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h00);
        send_frame(7, 10, -1, 4);
        exp_bad = 2;
        check_step("rxer", b0, t0, 60, 1, 1'b1);

        // 40-byte runt with valid FCS and no preamble.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(36, 8'h40);
        send_frame(0, -1, -1, 4);
        exp_bad = 3;
        check_step("runt", b0, t0, 36, 1, 1'b1);
        check_data("runt", b0);
        check("runt.last_data", last_data, 8'h63);

        // 4-byte frame never fills the delay line.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(0, 8'h00);
        send_frame(7, -1, -1, 4);
        exp_bad = 4;
        check_step("tiny", b0, t0, 0, 0, 1'b0);

        // 1600-byte oversize frame.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(1596, 8'h00);
        while (exp_q.size() > 1515) void'(exp_q.pop_back());
        mark_idx = 1519;
        send_frame(7, -1, -1, 6);
        mark_idx = -1;
        exp_bad = 5;
        check_step("oversize", b0, t0, 1515, 1, 1'b1);
        check_data("oversize", b0);
        check("oversize.last_data", last_data, 8'hEA);
        check("oversize.tlast_cyc", tlast_cyc, mark_cyc);

        // Two good frames with a single dv-low cycle between them.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h80);
        send_frame(7, -1, -1, 1);
        build(60, 8'hC0);
        send_frame(7, -1, -1, 4);
        exp_good = 3;
        check_step("b2b", b0, t0, 120, 2, 1'b0);
        check_data("b2b", b0);
        check("b2b.latency", tlast_cyc, dv0_cyc);

        // Broken preamble, then an over-long preamble: both dropped.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h00);
        exp_q.delete();
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8, -1, -1, 4);
        check_step("badpre", b0, t0, 0, 0, 1'b0);

        // Reset pulse at payload byte 30 with dv held high.
        t0 = n_tlast; exp_q.delete();
        build(60, 8'h00);
        send_frame(7, -1, 30, 4);
        exp_good = 0; exp_bad = 0;
        check("rstmid.beats_after", rx_q.size() - post_rst_beats, 0);
        check("rstmid.tlast", n_tlast - t0, 0);
        check("rstmid.good", stat_good, 0);
        check("rstmid.bad", stat_bad, 0);

        // Normal reception afterwards.
        b0 = rx_q.size(); t0 = n_tlast; exp_q.delete();
        build(60, 8'h10);
        send_frame(7, -1, -1, 4);
        exp_good = 1;
        check_step("after_rst", b0, t0, 60, 1, 1'b0);
        check_data("after_rst", b0);

        check("idle_outputs_zero", idle_junk, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
